// File: rtl/level_timer.sv
// Level countdown timer: loads an allotted time (in BCD seconds) for the
// current game level, counts it down once per TICK_DIV clocks while run
// is high, and flags a warning near the end and expiry at zero.
//
// Ports:
//   clk          - clock, rising-edge active
//   reset        - asynchronous, active-low reset
//   game_level   - current user level, selects the allotted time
//   load         - one-cycle request to load the allotted time
//   run          - level-sensitive countdown enable
//   time_bcd     - remaining seconds as BCD, units digit in [3:0]
//   running      - high while counting
//   warning      - high when 0 < remaining < WARN_SECS (counting or paused)
//   expired      - sticky expiry flag, cleared by the next load
//   expire_pulse - one-cycle strobe on entry to expiry
module level_timer #(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned LEVEL_W    = 8,
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned WARN_SECS  = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LEVEL_W-1:0]      game_level,
  input  logic                    load,
  input  logic                    run,
  output logic [4*NUM_DIGITS-1:0] time_bcd,
  output logic                    running,
  output logic                    warning,
  output logic                    expired,
  output logic                    expire_pulse
);

  localparam int unsigned TIME_W = 4 * NUM_DIGITS;
  localparam int unsigned PRE_W  = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0]  PRE_MAX    = PRE_W'(TICK_DIV - 1);
  localparam logic [7:0]        WARN_BCD   = {4'(WARN_SECS / 10), 4'(WARN_SECS % 10)};
  localparam logic [TIME_W-1:0] RESET_TIME = TIME_W'(12'h200);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                running_q, running_d;
  logic                warning_q, warning_d;
  logic                expired_q, expired_d;
  logic                pulse_q, pulse_d;

  // Allotted seconds per level, as 3-digit BCD.
  function automatic logic [11:0] allot_bcd(input logic [LEVEL_W-1:0] lvl);
    logic [11:0] v;
    case (32'(lvl))
      32'd0:   v = 12'h200;
      32'd1:   v = 12'h100;
      32'd2:   v = 12'h060;
      32'd3:   v = 12'h055;
      32'd4:   v = 12'h050;
      32'd5:   v = 12'h045;
      32'd6:   v = 12'h035;
      32'd7:   v = 12'h030;
      32'd8:   v = 12'h025;
      32'd9:   v = 12'h020;
      32'd10:  v = 12'h015;
      default: v = 12'h010;
    endcase
    return v;
  endfunction

  // BCD decrement by one; only applied to a non-zero value.
  function automatic logic [TIME_W-1:0] bcd_dec(input logic [TIME_W-1:0] t);
    logic [TIME_W-1:0] r;
    logic              borrow;
    r      = t;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (t[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = t[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    pre_d   = pre_q;
    pulse_d = 1'b0;

    if (load) begin
      // Load wins over a coincident tick or expiry.
      time_d  = TIME_W'(allot_bcd(game_level));
      pre_d   = '0;
      state_d = run ? ST_COUNT : ST_PAUSED;
    end else begin
      case (state_q)
        ST_COUNT: begin
          if (!run) begin
            state_d = ST_PAUSED;
          end else if (pre_q == PRE_MAX) begin
            pre_d  = '0;
            time_d = bcd_dec(time_q);
            if (time_d == '0) begin
              state_d = ST_EXPIRED;
              pulse_d = 1'b1;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        ST_PAUSED: begin
          // Prescaler is held, so the interrupted period resumes.
          if (run) state_d = ST_COUNT;
        end
        ST_IDLE, ST_EXPIRED: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end

    running_d = (state_d == ST_COUNT);
    expired_d = (state_d == ST_EXPIRED);
    // BCD compares like binary, so the low two digits compare directly.
    warning_d = ((state_d == ST_COUNT) || (state_d == ST_PAUSED)) &&
                (time_d != '0) &&
                (time_d[TIME_W-1:8] == '0) &&
                (time_d[7:0] < WARN_BCD);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      time_q    <= RESET_TIME;
      pre_q     <= '0;
      running_q <= 1'b0;
      warning_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      pre_q     <= pre_d;
      running_q <= running_d;
      warning_q <= warning_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
    end
  end

  assign time_bcd     = time_q;
  assign running      = running_q;
  assign warning      = warning_q;
  assign expired      = expired_q;
  assign expire_pulse = pulse_q;

endmodule

// File: tb/tb_level_timer.sv
// Self-checking bench for level_timer with TICK_DIV=4: a 3-digit instance
// carries most scenarios, a 4-digit instance shares its stimulus for the
// reset/reload case. Expected time values go into a scoreboard queue as
// stimulus is driven and are popped when the DUT output is sampled.
module tb_level_timer;

  localparam int unsigned TD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  game_level = 8'd0;

  logic [11:0] t3;
  logic [15:0] t4;
  logic        cnt3, warn3, exp3, pul3;
  logic        cnt4, warn4, exp4, pul4;
  logic [3:0]  f3, f4;

  // Flag nibble: {running, warning, expired, expire_pulse}
  assign f3 = {cnt3, warn3, exp3, pul3};
  assign f4 = {cnt4, warn4, exp4, pul4};

  level_timer #(.NUM_DIGITS(3), .LEVEL_W(8), .TICK_DIV(TD), .WARN_SECS(10)) u_dut3 (
    .clk(clk), .reset(reset), .game_level(game_level), .load(load), .run(run),
    .time_bcd(t3), .running(cnt3), .warning(warn3), .expired(exp3), .expire_pulse(pul3)
  );

  level_timer #(.NUM_DIGITS(4), .LEVEL_W(8), .TICK_DIV(TD), .WARN_SECS(10)) u_dut4 (
    .clk(clk), .reset(reset), .game_level(game_level), .load(load), .run(run),
    .time_bcd(t4), .running(cnt4), .warning(warn4), .expired(exp4), .expire_pulse(pul4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got 0x%0h with no expectation queued", obs);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse load for one cycle; returns at the negedge after the load edge.
  task automatic do_load(input logic [7:0] lvl, input logic r);
    game_level = lvl;
    run        = r;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    reset = 1'b0;
    cyc(2);
    check("rst_time3", 32'(t3), 32'h200);
    check("rst_time4", 32'(t4), 32'h0200);
    check("rst_flags3", 32'(f3), 32'h0);
    check("rst_flags4", 32'(f4), 32'h0);

    // IDLE ignores run
    reset = 1'b1;
    run   = 1'b1;
    cyc(3);
    check("idle_time", 32'(t3), 32'h200);
    check("idle_flags", 32'(f3), 32'h0);

    // Level 3, run=1: 055, 054 after 4 cycles, 053 after 8
    push("l3_t0", 32'h055);
    push("l3_t4", 32'h054);
    push("l3_t8", 32'h053);
    do_load(8'd3, 1'b1);
    pop_check(32'(t3));
    check("l3_flags", 32'(f3), 32'h8);
    cyc(4);
    pop_check(32'(t3));
    cyc(4);
    pop_check(32'(t3));

    // Level 2 over four ticks: BCD borrow 060 -> 059
    push("l2_0", 32'h060);
    push("l2_1", 32'h059);
    push("l2_2", 32'h058);
    push("l2_3", 32'h057);
    push("l2_4", 32'h056);
    do_load(8'd2, 1'b1);
    pop_check(32'(t3));
    for (int i = 1; i <= 4; i++) begin
      cyc(4);
      pop_check(32'(t3));
    end

    // Pause 2 cycles into a period for 10 cycles; prescaler is held
    cyc(2);
    run = 1'b0;
    cyc(1);
    check("pause_flags", 32'(f3), 32'h0);
    cyc(9);
    check("pause_hold", 32'(t3), 32'h056);
    run = 1'b1;
    cyc(1);
    check("resume_flags", 32'(f3), 32'h8);
    cyc(1);
    check("resume_no_tick", 32'(t3), 32'h056);
    cyc(1);
    check("resume_tick", 32'(t3), 32'h055);

    // Load on the same edge as a tick: no decrement, next tick 4 later
    cyc(3);
    do_load(8'd4, 1'b1);
    check("ld_tick_val", 32'(t3), 32'h050);
    cyc(3);
    check("ld_tick_hold", 32'(t3), 32'h050);
    cyc(1);
    check("ld_tick_next", 32'(t3), 32'h049);

    // Default entry run to expiry
    do_load(8'd200, 1'b1);
    check("def_time", 32'(t3), 32'h010);
    check("def_flags", 32'(f3), 32'h8);
    for (int s = 9; s >= 1; s--) push($sformatf("warn_t%0d", s), 32'(s));
    for (int s = 9; s >= 1; s--) begin
      cyc(4);
      pop_check(32'(t3));
      check("warn_flags", 32'(f3), 32'hC);
    end
    cyc(4);
    check("exp_time", 32'(t3), 32'h000);
    check("exp_flags", 32'(f3), 32'h3);
    cyc(1);
    check("exp_pulse_end", 32'(f3), 32'h2);
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      cyc(1);
      check("exp_sticky_t", 32'(t3), 32'h000);
      check("exp_sticky_f", 32'(f3), 32'h2);
    end

    // Load clears expiry; then warning while paused
    do_load(8'd11, 1'b0);
    check("reload_time", 32'(t3), 32'h010);
    check("reload_flags", 32'(f3), 32'h0);
    run = 1'b1;
    cyc(1);
    check("reload_run", 32'(f3), 32'h8);
    cyc(36);
    check("near_end_t", 32'(t3), 32'h001);
    check("near_end_f", 32'(f3), 32'hC);
    run = 1'b0;
    cyc(1);
    check("paused_warn", 32'(f3), 32'h4);
    run = 1'b1;
    cyc(1);
    cyc(3);
    check("pre_exp_t", 32'(t3), 32'h001);

    // Load on the edge that would expire: load wins, no pulse
    do_load(8'd1, 1'b1);
    check("ld_exp_time", 32'(t3), 32'h100);
    check("ld_exp_flags", 32'(f3), 32'h8);
    cyc(1);
    check("ld_exp_after", 32'(f3), 32'h8);

    // Reset mid-count, then reload level 0
    do_load(8'd5, 1'b1);
    cyc(2);
    check("mid_t3", 32'(t3), 32'h045);
    check("mid_t4", 32'(t4), 32'h0045);
    #2 reset = 1'b0;
    #1;
    check("async_rst_t3", 32'(t3), 32'h200);
    check("async_rst_t4", 32'(t4), 32'h0200);
    check("async_rst_f3", 32'(f3), 32'h0);
    check("async_rst_f4", 32'(f4), 32'h0);
    cyc(2);
    check("in_rst_t4", 32'(t4), 32'h0200);
    reset = 1'b1;
    run   = 1'b1;
    cyc(2);
    check("post_rst_t3", 32'(t3), 32'h200);
    check("post_rst_f4", 32'(f4), 32'h0);
    do_load(8'd0, 1'b0);
    check("l0_t3", 32'(t3), 32'h200);
    check("l0_t4", 32'(t4), 32'h0200);
    check("l0_f4", 32'(f4), 32'h0);
    run = 1'b1;
    cyc(1 + TD);
    check("l0_tick_t4", 32'(t4), 32'h0199);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
